// File: rtl/zx_cartridge_mapper_pkg.sv
// zx_cart_pkg: shared definitions for the ZX cartridge mapper.
//   cmd_e       - command field (D[7:6]) encodings used in command mode
//   MODE_*      - values of the mapper MODE parameter
//   in_window() - decode of the cartridge ROM window from A15/A14/A13
package zx_cart_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_INC  = 2'b01,
        CMD_NOP  = 2'b10,
        CMD_LOCK = 2'b11
    } cmd_e;

    localparam int MODE_LEGACY = 0;
    localparam int MODE_CMD    = 1;

    // 8K window needs A13 low as well; 16K window ignores A13.
    function automatic logic in_window(input logic a15, input logic a14,
                                       input logic a13, input logic win_16k);
        return !a15 && !a14 && (win_16k || !a13);
    endfunction

endpackage

// File: rtl/zx_cartridge_mapper_if.sv
// zx_cartridge_mapper_if: Z80 bus as seen by the cartridge mapper.
//   master - Z80 side: drives strobes, address bits and write data,
//            receives readback data/enable.
//   slave  - mapper side.
// Signals: iorq_n, rd_n, wr_n, mreq_n (active-low strobes), A7/A13/A14/A15
// (address bits), D (write data), D_out/D_oe (readback data and enable).
interface zx_cartridge_mapper_if;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       mreq_n;
    logic       A7;
    logic       A13;
    logic       A14;
    logic       A15;
    logic [7:0] D;
    logic [7:0] D_out;
    logic       D_oe;

    modport master (
        output iorq_n, rd_n, wr_n, mreq_n, A7, A13, A14, A15, D,
        input  D_out, D_oe
    );

    modport slave (
        input  iorq_n, rd_n, wr_n, mreq_n, A7, A13, A14, A15, D,
        output D_out, D_oe
    );
endinterface

// File: rtl/zx_cartridge_mapper_bus_sync.sv
// zx_bus_sync: multi-flop synchroniser for one asynchronous active-low bus
// strobe, with rising-edge detect on the synchronised value.
//   clk, reset_n - clock, synchronous active-low reset (chain resets to 1 = idle)
//   din          - raw asynchronous input
//   dout         - synchronised level (STAGES clk late)
//   rise         - one-clk pulse when dout goes 0 -> 1
module zx_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/zx_cartridge_mapper.sv
// zx_cartridge_mapper: clocked ZX cartridge bank mapper.
// Decodes Z80 I/O writes with A7=0 (synchronised into clk) and on the end of
// each write either increments the bank (MODE=0) or executes the command in
// D[7:6] (MODE=1: load / increment / nop / lock). Reaching SELF_LOCK_VAL locks
// the mapper; only reset unlocks it. The ROM read path is combinational.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset
//   bus          - Z80 bus (slave modport)
//   CR_ROM_A     - cartridge ROM bank address
//   CR_ROM_oe_n  - cartridge ROM output enable, active low
//   ZX_ROM_blk   - blocks the internal ROM while the cartridge is mapped
//   locked       - lock status
// Optional macro CART_READBACK_EN: I/O read with A7=0 returns
// {locked, 0.., bank} on bus.D_out with bus.D_oe high; otherwise both are 0.
module zx_cartridge_mapper
    import zx_cart_pkg::*;
#(
    parameter int BANK_W        = 6,
    parameter int SELF_LOCK_VAL = 63,
    parameter int MODE          = 0,
    parameter int WIN_16K       = 0,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    zx_cartridge_mapper_if.slave bus,
    output logic [BANK_W-1:0] CR_ROM_A,
    output logic              CR_ROM_oe_n,
    output logic              ZX_ROM_blk,
    output logic              locked
);

    localparam logic [BANK_W-1:0] LOCK_VAL = BANK_W'(SELF_LOCK_VAL);

    logic iorq_s, iorq_rise;
    logic wr_s, wr_rise_unused;

    zx_bus_sync #(.STAGES(SYNC_STAGES)) u_iorq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.iorq_n),
        .dout    (iorq_s),
        .rise    (iorq_rise)
    );

    zx_bus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.wr_n),
        .dout    (wr_s),
        .rise    (wr_rise_unused)
    );

    logic [BANK_W-1:0] bank_q, bank_d;
    logic              lock_q, lock_d;
    logic              pend_q, pend_d;
    logic [7:0]        data_q, data_d;

    logic              wr_active;
    logic              upd;
    logic [BANK_W-1:0] nxt_bank;

    // A7 is sampled raw every clk, so a mid-cycle change only blocks capture
    // from that clk on.
    assign wr_active = !iorq_s && !wr_s && !bus.A7;

    always_comb begin
        bank_d   = bank_q;
        lock_d   = lock_q;
        pend_d   = pend_q;
        data_d   = data_q;
        upd      = 1'b0;
        nxt_bank = bank_q;

        if (wr_active) begin
            pend_d = 1'b1;
            data_d = bus.D;
        end else if (iorq_rise && pend_q) begin
            pend_d = 1'b0;
            if (!lock_q) begin
                if (MODE == MODE_LEGACY) begin
                    upd      = 1'b1;
                    nxt_bank = bank_q + BANK_W'(1);
                end else begin
                    case (cmd_e'(data_q[7:6]))
                        CMD_LOAD: begin
                            upd      = 1'b1;
                            nxt_bank = data_q[BANK_W-1:0];
                        end
                        CMD_INC: begin
                            upd      = 1'b1;
                            nxt_bank = bank_q + BANK_W'(1);
                        end
                        CMD_NOP:  ;
                        CMD_LOCK: lock_d = 1'b1;
                    endcase
                end
                // Self-lock takes effect in the same clk as the bank update.
                if (upd) begin
                    bank_d = nxt_bank;
                    if (nxt_bank == LOCK_VAL) lock_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_q <= '0;
            lock_q <= 1'b0;
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            bank_q <= bank_d;
            lock_q <= lock_d;
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    // Read path uses the raw bus so it meets Z80 memory timing.
    logic in_win;
    assign in_win      = in_window(bus.A15, bus.A14, bus.A13, WIN_16K != 0);
    assign ZX_ROM_blk  = !lock_q && in_win && !bus.mreq_n;
    assign CR_ROM_oe_n = !(ZX_ROM_blk && !bus.rd_n);
    assign CR_ROM_A    = bank_q;
    assign locked      = lock_q;

`ifdef CART_READBACK_EN
    logic [7:0] rb_data;
    always_comb begin
        rb_data             = '0;
        rb_data[BANK_W-1:0] = bank_q;
        rb_data[7]          = lock_q;
    end
    assign bus.D_out = rb_data;
    assign bus.D_oe  = !bus.iorq_n && !bus.rd_n && !bus.A7;
`else
    assign bus.D_out = 8'h00;
    assign bus.D_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_zx_cartridge_mapper.sv
// Bench: three mapper configurations driven by one shared Z80 bus and checked
// against a transaction-level reference model.
//   u0: MODE=0, SELF_LOCK_VAL=3,  8K window
//   u1: MODE=1, SELF_LOCK_VAL=63, 8K window
//   u2: MODE=1, SELF_LOCK_VAL=10, 16K window
module tb_zx_cartridge_mapper;

    localparam int SYNC = 2;
    localparam int N    = 3;
`ifdef CART_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iorq_n, rd_n, wr_n, mreq_n;
    logic [15:0] addr;
    logic [7:0]  dbus;

    logic [N-1:0][5:0] rom_a;
    logic [N-1:0][7:0] d_out;
    logic [N-1:0]      oe_n, blk, lck, d_oe;

    always #5 clk = ~clk;

    zx_cartridge_mapper_if bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign bus[g].iorq_n = iorq_n;
        assign bus[g].rd_n   = rd_n;
        assign bus[g].wr_n   = wr_n;
        assign bus[g].mreq_n = mreq_n;
        assign bus[g].A7     = addr[7];
        assign bus[g].A13    = addr[13];
        assign bus[g].A14    = addr[14];
        assign bus[g].A15    = addr[15];
        assign bus[g].D      = dbus;
        assign d_out[g]      = bus[g].D_out;
        assign d_oe[g]       = bus[g].D_oe;
    end

    zx_cartridge_mapper #(.BANK_W(6), .SELF_LOCK_VAL(3), .MODE(0), .WIN_16K(0), .SYNC_STAGES(SYNC)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus[0]),
        .CR_ROM_A(rom_a[0]), .CR_ROM_oe_n(oe_n[0]), .ZX_ROM_blk(blk[0]), .locked(lck[0]));
    zx_cartridge_mapper #(.BANK_W(6), .SELF_LOCK_VAL(63), .MODE(1), .WIN_16K(0), .SYNC_STAGES(SYNC)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus[1]),
        .CR_ROM_A(rom_a[1]), .CR_ROM_oe_n(oe_n[1]), .ZX_ROM_blk(blk[1]), .locked(lck[1]));
    zx_cartridge_mapper #(.BANK_W(6), .SELF_LOCK_VAL(10), .MODE(1), .WIN_16K(1), .SYNC_STAGES(SYNC)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus[2]),
        .CR_ROM_A(rom_a[2]), .CR_ROM_oe_n(oe_n[2]), .ZX_ROM_blk(blk[2]), .locked(lck[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: bank value and lock per instance.
    int m_mode [N] = '{0, 1, 1};
    int m_sl   [N] = '{3, 63, 10};
    int m_win  [N] = '{0, 0, 1};
    int m_bank [N];
    bit m_lock [N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bank[i] = 0;
            m_lock[i] = 1'b0;
        end
    endtask

    task automatic model_commit(input int i, input int d);
        int nb;
        bit upd;
        if (m_lock[i]) return;
        upd = 1'b0;
        nb  = m_bank[i];
        if (m_mode[i] == 0) begin
            upd = 1'b1;
            nb  = (m_bank[i] + 1) % 64;
        end else begin
            case (d / 64)
                0: begin upd = 1'b1; nb = d % 64; end
                1: begin upd = 1'b1; nb = (m_bank[i] + 1) % 64; end
                2: ;
                default: m_lock[i] = 1'b1;
            endcase
        end
        if (upd) begin
            m_bank[i] = nb;
            if (nb == m_sl[i]) m_lock[i] = 1'b1;
        end
    endtask

    function automatic bit m_blk(input int i);
        bit win;
        win = (addr < 16'h2000) || (m_win[i] != 0 && addr < 16'h4000);
        return !m_lock[i] && win && !mreq_n;
    endfunction

    function automatic bit m_oe_n(input int i);
        return !(m_blk(i) && !rd_n);
    endfunction

    task automatic bus_idle();
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1;
        addr = 16'hFFFF; dbus = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; dbus = d; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        addr = 16'hFFFF;
        if (!a[7]) for (int i = 0; i < N; i++) model_commit(i, int'(d));
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            checks += 6;
            if (rom_a[i] !== 6'd0) begin errors++; $display("FAIL reset_bank[%0d] got %0h want 0", i, rom_a[i]); end
            if (lck[i] !== 1'b0) begin errors++; $display("FAIL reset_lock[%0d] got %b want 0", i, lck[i]); end
            if (oe_n[i] !== 1'b1) begin errors++; $display("FAIL reset_oe_n[%0d] got %b want 1", i, oe_n[i]); end
            if (blk[i] !== 1'b0) begin errors++; $display("FAIL reset_blk[%0d] got %b want 0", i, blk[i]); end
            if (d_oe[i] !== 1'b0) begin errors++; $display("FAIL reset_d_oe[%0d] got %b want 0", i, d_oe[i]); end
            if (d_out[i] !== 8'h00) begin errors++; $display("FAIL reset_d_out[%0d] got %0h want 0", i, d_out[i]); end
        end
    endtask

    task automatic test_legacy_count();
        io_write(16'h0080, 8'h00);
        checks++;
        if (rom_a[0] !== 6'd0) begin errors++; $display("FAIL a7_high_ignored got %0d want 0", rom_a[0]); end
        for (int k = 1; k <= 4; k++) begin
            io_write(16'h007F, 8'h41);
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (rom_a[i] !== 6'(m_bank[i])) begin errors++; $display("FAIL inc_bank[%0d] step %0d got %0d want %0d", i, k, rom_a[i], m_bank[i]); end
                if (lck[i] !== m_lock[i]) begin errors++; $display("FAIL inc_lock[%0d] step %0d got %b want %b", i, k, lck[i], m_lock[i]); end
            end
        end
        checks += 2;
        if (rom_a[0] !== 6'd3) begin errors++; $display("FAIL legacy_frozen got %0d want 3", rom_a[0]); end
        if (lck[0] !== 1'b1) begin errors++; $display("FAIL legacy_selflock got %b want 1", lck[0]); end
    endtask

    task automatic test_lock_read();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) do_reset();
            @(negedge clk);
            addr = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
            #1;
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (oe_n[i] !== m_oe_n(i)) begin errors++; $display("FAIL lockrd_oe_n[%0d] pass %0d got %b want %b", i, pass, oe_n[i], m_oe_n(i)); end
                if (blk[i] !== m_blk(i)) begin errors++; $display("FAIL lockrd_blk[%0d] pass %0d got %b want %b", i, pass, blk[i], m_blk(i)); end
            end
            checks++;
            if (oe_n[0] !== (pass == 0)) begin errors++; $display("FAIL lockrd_u0 pass %0d got %b", pass, oe_n[0]); end
            bus_idle();
        end
    endtask

    task automatic test_window();
        logic [15:0] al [4] = '{16'h1FFF, 16'h2000, 16'h4001, 16'h3FFF};
        do_reset();
        for (int rdv = 0; rdv < 2; rdv++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                addr = al[k]; mreq_n = 1'b0; rd_n = 1'(rdv);
                #1;
                for (int i = 0; i < N; i++) begin
                    checks += 2;
                    if (oe_n[i] !== m_oe_n(i)) begin errors++; $display("FAIL win_oe_n[%0d] addr %h rd %0d got %b want %b", i, addr, rdv, oe_n[i], m_oe_n(i)); end
                    if (blk[i] !== m_blk(i)) begin errors++; $display("FAIL win_blk[%0d] addr %h rd %0d got %b want %b", i, addr, rdv, blk[i], m_blk(i)); end
                end
                if (rdv == 0 && k == 1) begin
                    checks += 2;
                    if (oe_n[0] !== 1'b1) begin errors++; $display("FAIL win8k_2000 got %b want 1", oe_n[0]); end
                    if (oe_n[2] !== 1'b0) begin errors++; $display("FAIL win16k_2000 got %b want 0", oe_n[2]); end
                end
            end
        end
        bus_idle();
    endtask

    task automatic test_cmd_load_inc();
        logic [7:0] dl [4] = '{8'h3E, 8'h40, 8'h3F, 8'h40};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            io_write(16'h001F, dl[k]);
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (rom_a[i] !== 6'(m_bank[i])) begin errors++; $display("FAIL cmd_bank[%0d] step %0d got %0d want %0d", i, k, rom_a[i], m_bank[i]); end
                if (lck[i] !== m_lock[i]) begin errors++; $display("FAIL cmd_lock[%0d] step %0d got %b want %b", i, k, lck[i], m_lock[i]); end
            end
        end
        checks += 3;
        if (rom_a[1] !== 6'd63 || lck[1] !== 1'b1) begin errors++; $display("FAIL cmd_selflock63 got %0d/%b want 63/1", rom_a[1], lck[1]); end
        if (rom_a[2] !== 6'd0) begin errors++; $display("FAIL cmd_wrap got %0d want 0", rom_a[2]); end
        if (lck[2] !== 1'b0) begin errors++; $display("FAIL cmd_wrap_lock got %b want 0", lck[2]); end
    endtask

    task automatic test_latency();
        do_reset();
        @(negedge clk);
        addr = 16'h0000; dbus = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rom_a[i] !== 6'd0) begin errors++; $display("FAIL latency_early[%0d] got %0d want 0", i, rom_a[i]); end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rom_a[i] !== 6'd1) begin errors++; $display("FAIL latency_update[%0d] got %0d want 1", i, rom_a[i]); end
        end
        for (int i = 0; i < N; i++) model_commit(i, 1);
        repeat (3) @(negedge clk);
        bus_idle();
    endtask

    task automatic test_lock_cmd_and_reset_midwrite();
        do_reset();
        io_write(16'h0000, 8'hC0);
        io_write(16'h0000, 8'h05);
        for (int i = 0; i < N; i++) begin
            checks += 2;
            if (rom_a[i] !== 6'(m_bank[i])) begin errors++; $display("FAIL lockcmd_bank[%0d] got %0d want %0d", i, rom_a[i], m_bank[i]); end
            if (lck[i] !== m_lock[i]) begin errors++; $display("FAIL lockcmd_lock[%0d] got %b want %b", i, lck[i], m_lock[i]); end
        end
        // Capture a load of 5, then reset before iorq_n rises.
        @(negedge clk);
        addr = 16'h007F; dbus = 8'h05; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        iorq_n = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        bus_idle();
        model_reset();
        for (int i = 0; i < N; i++) begin
            checks += 2;
            if (rom_a[i] !== 6'd0) begin errors++; $display("FAIL midreset_bank[%0d] got %0d want 0", i, rom_a[i]); end
            if (lck[i] !== 1'b0) begin errors++; $display("FAIL midreset_lock[%0d] got %b want 0", i, lck[i]); end
        end
    endtask

    task automatic test_readback();
        int e;
        do_reset();
        io_write(16'h0000, 8'h05);
        io_write(16'h0000, 8'hC0);
        for (int a7 = 0; a7 < 2; a7++) begin
            @(negedge clk);
            addr = (a7 != 0) ? 16'h00FF : 16'h007F; iorq_n = 1'b0; rd_n = 1'b0;
            #1;
            for (int i = 0; i < N; i++) begin
                e = RB_EN ? ((m_lock[i] ? 128 : 0) + m_bank[i]) : 0;
                checks += 2;
                if (d_oe[i] !== (RB_EN && a7 == 0)) begin errors++; $display("FAIL rb_d_oe[%0d] a7 %0d got %b", i, a7, d_oe[i]); end
                if (d_out[i] !== 8'(e)) begin errors++; $display("FAIL rb_d_out[%0d] got %0h want %0h", i, d_out[i], e); end
            end
            bus_idle();
            repeat (SYNC + 3) @(negedge clk);
        end
        checks++;
        if (d_out[1] !== (RB_EN ? 8'h85 : 8'h00)) begin errors++; $display("FAIL rb_u1_value got %0h", d_out[1]); end
    endtask

    task automatic test_random();
        int kind;
        logic [15:0] a;
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 48; n++) begin
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                do_reset();
            end else begin
                a = 16'($urandom);
                if (kind < 9) a[7] = 1'b0;
                d = 8'($urandom);
                if (kind < 6) d[7:6] = 2'($urandom_range(0, 2));
                io_write(a, d);
            end
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (rom_a[i] !== 6'(m_bank[i])) begin errors++; $display("FAIL rnd_bank[%0d] op %0d got %0d want %0d", i, n, rom_a[i], m_bank[i]); end
                if (lck[i] !== m_lock[i]) begin errors++; $display("FAIL rnd_lock[%0d] op %0d got %b want %b", i, n, lck[i], m_lock[i]); end
            end
            @(negedge clk);
            addr = 16'($urandom); mreq_n = 1'($urandom); rd_n = 1'($urandom);
            #1;
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (oe_n[i] !== m_oe_n(i)) begin errors++; $display("FAIL rnd_oe_n[%0d] addr %h got %b want %b", i, addr, oe_n[i], m_oe_n(i)); end
                if (blk[i] !== m_blk(i)) begin errors++; $display("FAIL rnd_blk[%0d] addr %h got %b want %b", i, addr, blk[i], m_blk(i)); end
            end
            bus_idle();
        end
    endtask

    initial begin
        bus_idle();
        reset_n = 1'b0;
        model_reset();
        test_reset();
        test_legacy_count();
        test_lock_read();
        test_window();
        test_cmd_load_inc();
        test_latency();
        test_lock_cmd_and_reset_midwrite();
        test_readback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
